// File: rtl/item_pos_gen.sv
// item_pos_gen: LFSR-driven, grid-aligned random position generator for NUM_ITEMS item slots.
// Optional build macro ITEM_GEN_AVOID_HEAD_EN: also reject candidates whose pixel position equals the snake head.

module item_pos_gen #(
  parameter int          NUM_ITEMS = 4,
  parameter int          CELL_PX   = 10,
  parameter int          COLS      = 64,
  parameter int          ROWS      = 48,
  parameter int          MARGIN    = 2,
  parameter int          MAX_TRIES = 8,
  parameter logic [15:0] SEED      = 16'hACE1,
  localparam int         IDX_W     = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1
) (
  input  logic                    vga_clk,
  input  logic                    reset_n,
  input  logic                    req,
  input  logic [IDX_W-1:0]        req_idx,
  input  logic [11:0]             head_x,
  input  logic [11:0]             head_y,
  output logic                    busy,
  output logic                    done,
  output logic [IDX_W-1:0]        done_idx,
  output logic                    fallback,
  output logic [12*NUM_ITEMS-1:0] x_pos,
  output logic [12*NUM_ITEMS-1:0] y_pos
);

  localparam int          TRY_W      = $clog2(MAX_TRIES + 1);
  localparam logic [15:0] SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [7:0]  CX_MASK    = 8'((1 << $clog2(COLS)) - 1);
  localparam logic [7:0]  CY_MASK    = 8'((1 << $clog2(ROWS)) - 1);
  localparam logic [11:0] X_LIM      = 12'(COLS - 2 * MARGIN);
  localparam logic [11:0] Y_LIM      = 12'(ROWS - 2 * MARGIN);
  localparam logic [11:0] FB_ROW_MAX = 12'(ROWS - MARGIN - 1);
  localparam logic [11:0] MARGIN_C   = 12'(MARGIN);
  localparam logic [11:0] PX_C       = 12'(CELL_PX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW   = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [15:0]       lfsr_reg, lfsr_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [TRY_W-1:0]  try_reg, try_next, try_inc;
  logic [7:0]        cx_reg, cx_next;
  logic [7:0]        cy_reg, cy_next;
  logic              fb_reg, fb_next;

  logic              commit_en;
  logic [11:0]       commit_x, commit_y;
  logic [11:0]       cand_x, cand_y;
  logic [11:0]       fb_row_raw, fb_row;
  logic              in_range, any_hit, head_hit, reject, idx_ok;
  logic [NUM_ITEMS-1:0] slot_hit;

  // Galois form, shifting right: the feedback bit is XORed into the tap positions.
  assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_TAPS : 16'h0000);

  assign idx_ok     = (32'(req_idx) < 32'(NUM_ITEMS));
  assign cand_x     = {4'b0000, cx_reg} + MARGIN_C;
  assign cand_y     = {4'b0000, cy_reg} + MARGIN_C;
  assign in_range   = ({4'b0000, cx_reg} < X_LIM) && ({4'b0000, cy_reg} < Y_LIM);
  assign fb_row_raw = MARGIN_C + 12'(idx_reg);
  assign fb_row     = (fb_row_raw > FB_ROW_MAX) ? FB_ROW_MAX : fb_row_raw;
  assign any_hit    = |slot_hit;
  assign reject     = !in_range || any_hit || head_hit;
  assign try_inc    = try_reg + TRY_W'(1);

`ifdef ITEM_GEN_AVOID_HEAD_EN
  logic [11:0] cand_px_x, cand_px_y;
  assign cand_px_x = cand_x * PX_C;
  assign cand_px_y = cand_y * PX_C;
  assign head_hit  = (cand_px_x == head_x) && (cand_px_y == head_y);
`else
  logic unused_head;
  assign unused_head = ^{head_x, head_y};
  assign head_hit    = 1'b0;
`endif

  // Each slot owns its cell registers; only the slot latched at request time is rewritten.
  generate
    for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_slot
      logic [11:0] cell_x_reg;
      logic [11:0] cell_y_reg;

      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          cell_x_reg <= 12'(MARGIN + 2 * gi);
          cell_y_reg <= MARGIN_C;
        end else if (commit_en && (idx_reg == IDX_W'(gi))) begin
          cell_x_reg <= commit_x;
          cell_y_reg <= commit_y;
        end
      end

      assign slot_hit[gi] = (idx_reg != IDX_W'(gi)) &&
                            (cell_x_reg == cand_x) && (cell_y_reg == cand_y);
      assign x_pos[12*gi +: 12] = cell_x_reg * PX_C;
      assign y_pos[12*gi +: 12] = cell_y_reg * PX_C;
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    try_next   = try_reg;
    cx_next    = cx_reg;
    cy_next    = cy_reg;
    fb_next    = fb_reg;
    commit_en  = 1'b0;
    commit_x   = cand_x;
    commit_y   = cand_y;
    case (state_reg)
      IDLE: begin
        if (req && idx_ok) begin
          idx_next   = req_idx;
          try_next   = '0;
          fb_next    = 1'b0;
          state_next = DRAW;
        end
      end
      DRAW: begin
        cx_next    = lfsr_reg[15:8] & CX_MASK;
        cy_next    = lfsr_reg[7:0] & CY_MASK;
        state_next = CHECK;
      end
      CHECK: begin
        // Slot registers are written on the way into COMMIT so they are valid while done is high.
        if (!reject) begin
          commit_en  = 1'b1;
          fb_next    = 1'b0;
          state_next = COMMIT;
        end else if (try_inc == TRY_W'(MAX_TRIES)) begin
          try_next   = try_inc;
          commit_en  = 1'b1;
          commit_x   = MARGIN_C;
          commit_y   = fb_row;
          fb_next    = 1'b1;
          state_next = COMMIT;
        end else begin
          try_next   = try_inc;
          state_next = DRAW;
        end
      end
      COMMIT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      lfsr_reg  <= SEED_EFF;
      idx_reg   <= '0;
      try_reg   <= '0;
      cx_reg    <= '0;
      cy_reg    <= '0;
      fb_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      lfsr_reg  <= lfsr_next;
      idx_reg   <= idx_next;
      try_reg   <= try_next;
      cx_reg    <= cx_next;
      cy_reg    <= cy_next;
      fb_reg    <= fb_next;
    end
  end

  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == COMMIT);
  assign done_idx = idx_reg;
  assign fallback = done && fb_reg;

endmodule
